// File: rtl/axi_pkg.sv
// AXI encodings, channel FSM state types and burst address stepping
// shared by the SRAM-backed AXI responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

    function automatic logic burst_illegal(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd3) || (burst == 2'b11);
    endfunction

    // Illegal bursts still step like INCR so every beat is consumed.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] wrap_mask;
        logic [31:0] na;
        step      = 32'd1 << size;
        wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;
        na        = addr + step;
        if (!burst_illegal(size, burst)) begin
            case (burst)
                BURST_FIXED: na = addr;
                BURST_WRAP:  na = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
                default:     na = addr + step;
            endcase
        end
        return na;
    endfunction

endpackage

// File: rtl/sram_dp.sv
// Byte-enabled SRAM: one write port, one registered read port that holds
// its output when not enabled and returns pre-write data on collisions.
module sram_dp #(
    parameter int WORDS = 4096,
    parameter int DW    = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wbe,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [WORDS];
    logic [DW-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder terminating the remapped memory window in on-chip SRAM;
// read and write channels run independent FSMs.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 32,
    parameter int         DATA_WIDTH  = 64,
    parameter int         ID_WIDTH    = 4,
    parameter int         MEM_WORDS   = 4096,
    parameter logic [3:0] BASE_NIBBLE = 4'h1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    wr_state_e             wst_d, wst_q;
    logic [ID_WIDTH-1:0]   aw_id_d, aw_id_q;
    logic [ADDR_WIDTH-1:0] aw_addr_d, aw_addr_q;
    logic [7:0]            aw_len_d, aw_len_q, w_cnt_d, w_cnt_q;
    logic [2:0]            aw_size_d, aw_size_q;
    logic [1:0]            aw_burst_d, aw_burst_q;
    logic                  w_slv_d, w_slv_q, w_dec_d, w_dec_q, w_last;

    rd_state_e             rst_d, rst_q;
    logic [ID_WIDTH-1:0]   ar_id_d, ar_id_q;
    logic [ADDR_WIDTH-1:0] ar_addr_d, ar_addr_q, r_next;
    logic [7:0]            ar_len_d, ar_len_q, r_cnt_d, r_cnt_q;
    logic [2:0]            ar_size_d, ar_size_q;
    logic [1:0]            ar_burst_d, ar_burst_q;
    logic                  r_slv_d, r_slv_q, r_dec_d, r_dec_q, r_last;

    logic                  mem_we, mem_re;
    logic [IDX_W-1:0]      mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    always_comb begin
        wst_d      = wst_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_slv_d    = w_slv_q;
        w_dec_d    = w_dec_q;
        w_last     = (w_cnt_q == aw_len_q);
        mem_we        = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wst_q)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) begin
                    aw_id_d    = s_axi_awid;
                    aw_addr_d  = s_axi_awaddr;
                    aw_len_d   = s_axi_awlen;
                    aw_size_d  = s_axi_awsize;
                    aw_burst_d = s_axi_awburst;
                    w_cnt_d    = '0;
                    w_slv_d    = burst_illegal(s_axi_awsize, s_axi_awburst);
                    w_dec_d    = (s_axi_awaddr[ADDR_WIDTH-1 -: 4] != BASE_NIBBLE);
                    wst_d      = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_we    = !w_dec_q && !burst_illegal(aw_size_q, aw_burst_q);
                    // The beat counter ends the burst; wlast only flags a protocol error.
                    if (s_axi_wlast != w_last) w_slv_d = 1'b1;
                    aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
                    w_cnt_d   = w_cnt_q + 8'd1;
                    if (w_last) wst_d = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wst_d = W_IDLE;
            end
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        rst_d      = rst_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        r_slv_d    = r_slv_q;
        r_dec_d    = r_dec_q;
        r_next     = next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
        r_last     = (r_cnt_q == ar_len_q);
        mem_re        = 1'b0;
        mem_raddr     = ar_addr_q[IDX_W+2:3];
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        case (rst_q)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) begin
                    ar_id_d    = s_axi_arid;
                    ar_addr_d  = s_axi_araddr;
                    ar_len_d   = s_axi_arlen;
                    ar_size_d  = s_axi_arsize;
                    ar_burst_d = s_axi_arburst;
                    r_cnt_d    = '0;
                    r_slv_d    = burst_illegal(s_axi_arsize, s_axi_arburst);
                    r_dec_d    = (s_axi_araddr[ADDR_WIDTH-1 -: 4] != BASE_NIBBLE);
                    rst_d      = R_FETCH;
                end
            end
            R_FETCH: begin
                mem_re = 1'b1;
                rst_d  = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = r_last;
                if (s_axi_rready) begin
                    if (r_last) begin
                        rst_d = R_IDLE;
                    end else begin
                        // Prefetch the next word so beats stream back-to-back.
                        ar_addr_d = r_next;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        mem_re    = 1'b1;
                        mem_raddr = r_next[IDX_W+2:3];
                    end
                end
            end
            default: rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wst_q      <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_slv_q    <= 1'b0;
            w_dec_q    <= 1'b0;
            rst_q      <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            r_slv_q    <= 1'b0;
            r_dec_q    <= 1'b0;
        end else begin
            wst_q      <= wst_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_slv_q    <= w_slv_d;
            w_dec_q    <= w_dec_d;
            rst_q      <= rst_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            r_slv_q    <= r_slv_d;
            r_dec_q    <= r_dec_d;
        end
    end

    sram_dp #(
        .WORDS (MEM_WORDS),
        .DW    (DATA_WIDTH)
    ) u_sram (
        .clk   (aclk),
        .rst_n (aresetn),
        .we    (mem_we),
        .waddr (aw_addr_q[IDX_W+2:3]),
        .wdata (s_axi_wdata),
        .wbe   (s_axi_wstrb),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign s_axi_bid   = aw_id_q;
    assign s_axi_bresp = w_dec_q ? RESP_DECERR : (w_slv_q ? RESP_SLVERR : RESP_OKAY);
    assign s_axi_rid   = ar_id_q;
    assign s_axi_rresp = r_dec_q ? RESP_DECERR : (r_slv_q ? RESP_SLVERR : RESP_OKAY);
    assign s_axi_rdata = r_dec_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a byte-level memory model feeds a queue
// of expected read beats that is drained as R beats arrive.
module tb_axi_sram_slave;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    axi_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
        .s_axi_awqos(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
        .s_axi_arqos(4'h0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] model [int];
    rexp_t       sb [$];
    logic [63:0] wd [16];
    logic [7:0]  ws [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int i);
        int unsigned sz, wb, base;
        sz = 1 << size;
        if (size <= 3 && burst == 2'b00) return a;
        if (size <= 3 && burst == 2'b10) begin
            wb   = (int'(len) + 1) * sz;
            base = a - (a % wb);
            return base + ((a - base + i * sz) % wb);
        end
        return a + i * sz;
    endfunction

    task automatic model_write(input int idx, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        w = model.exists(idx) ? model[idx] : 64'hx;
        for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[idx] = w;
    endtask

    task automatic push_exp(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        rexp_t e;
        logic [31:0] ba;
        int idx;
        for (int i = 0; i <= int'(len); i++) begin
            ba     = beat_addr(a, len, size, burst, i);
            idx    = int'(ba[14:3]);
            e.id   = id;
            e.last = (i == int'(len));
            if (a[31:28] != 4'h1) begin
                e.data = 64'h0;
                e.resp = 2'b11;
            end else begin
                e.data = model.exists(idx) ? model[idx] : 64'hx;
                e.resp = (size > 3 || burst == 2'b11) ? 2'b10 : 2'b00;
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_b(input logic [3:0] id, input logic [1:0] exp);
        int tmo = 0;
        while (!bvalid && tmo < 50) begin @(negedge aclk); tmo++; end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, exp);
        chk("bid", bid, id);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input bit bad_last, input bit chk_timing);
        logic [1:0]  exp;
        logic [31:0] ba;
        bit          wr_ok;
        int          tmo;
        wr_ok = (a[31:28] == 4'h1) && (size <= 3) && (burst != 2'b11);
        exp   = (a[31:28] != 4'h1) ? 2'b11 :
                ((size > 3 || burst == 2'b11 || bad_last) ? 2'b10 : 2'b00);
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        tmo = 0;
        while (!awready && tmo < 50) begin @(negedge aclk); tmo++; end
        chk("awready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        if (chk_timing) chk("wready_after_aw", wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wvalid = 1'b1;
            wlast = bad_last ? (i == 0) : (i == int'(len));
            tmo = 0;
            while (!wready && tmo < 50) begin @(negedge aclk); tmo++; end
            if (!wready) chk("wready_timeout", wready, 1);
            if (wr_ok) begin
                ba = beat_addr(a, len, size, burst, i);
                model_write(int'(ba[14:3]), wd[i], ws[i]);
            end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (chk_timing) chk("bvalid_after_wlast", bvalid, 1);
        wait_b(id, exp);
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int tmo = 0;
        push_exp(id, a, len, size, burst);
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && tmo < 50) begin @(negedge aclk); tmo++; end
        chk("arready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic collect_r(input int n, input bit stall);
        rexp_t e;
        int    tmo;
        rready = !stall;
        for (int i = 0; i < n; i++) begin
            tmo = 0;
            while (!rvalid && tmo < 50) begin @(negedge aclk); tmo++; end
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL r_scoreboard_empty: observed 0 entries expected >0");
                break;
            end
            e = sb.pop_front();
            if (stall) begin
                chk("r_stall_data", rdata, e.data);
                @(negedge aclk);
                chk("r_stall_valid_held", rvalid, 1);
                chk("r_stall_data_held", rdata, e.data);
                chk("r_stall_last_held", rlast, e.last);
                rready = 1'b1;
            end
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, e.data);
            chk("rresp", rresp, e.resp);
            chk("rlast", rlast, e.last);
            chk("rid", rid, e.id);
            @(negedge aclk);
            if (stall) rready = 1'b0;
        end
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Single INCR beat with latency checks on both channels
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        write_burst(4'h3, 32'h1000_0008, 8'd0, 3'd3, 2'b01, 1'b0, 1'b1);
        issue_ar(4'h5, 32'h1000_0008, 8'd0, 3'd3, 2'b01);
        chk("rvalid_t+1_low", rvalid, 0);
        @(negedge aclk);
        chk("rvalid_t+2_high", rvalid, 1);
        collect_r(1, 1'b0);

        // INCR len=7, read back both streaming and with rready toggling
        for (int i = 0; i < 8; i++) begin
            wd[i] = 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(i * 17 + 3);
            ws[i] = 8'hFF;
        end
        write_burst(4'h1, 32'h1000_0100, 8'd7, 3'd3, 2'b01, 1'b0, 1'b0);
        issue_ar(4'h2, 32'h1000_0100, 8'd7, 3'd3, 2'b01);
        collect_r(8, 1'b1);
        issue_ar(4'h6, 32'h1000_0100, 8'd7, 3'd3, 2'b01);
        collect_r(8, 1'b0);

        // WRAP len=3 from 0x18: lands on 0x18,0x00,0x08,0x10
        for (int i = 0; i < 4; i++) begin
            wd[i] = 64'hC0DE_0000_0000_0000 + 64'(i + 1);
            ws[i] = 8'hFF;
        end
        write_burst(4'h7, 32'h1000_0018, 8'd3, 3'd3, 2'b10, 1'b0, 1'b0);
        issue_ar(4'h8, 32'h1000_0000, 8'd3, 3'd3, 2'b01);
        collect_r(4, 1'b0);
        issue_ar(4'h9, 32'h1000_0018, 8'd3, 3'd3, 2'b10);
        collect_r(4, 1'b0);

        // Out-of-window write/read: DECERR, SRAM word 0 untouched, zero data
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        wd[1] = 64'hEEEE_EEEE_EEEE_EEEE; ws[1] = 8'hFF;
        write_burst(4'hA, 32'h2000_0000, 8'd1, 3'd3, 2'b01, 1'b0, 1'b0);
        issue_ar(4'hB, 32'h2000_0000, 8'd1, 3'd3, 2'b01);
        collect_r(2, 1'b0);
        issue_ar(4'hC, 32'h1000_0000, 8'd0, 3'd3, 2'b01);
        collect_r(1, 1'b0);

        // Reserved burst type: SLVERR and no write
        wd[0] = 64'h0BAD_0BAD_0BAD_0BAD; ws[0] = 8'hFF;
        write_burst(4'hD, 32'h1000_0008, 8'd0, 3'd3, 2'b11, 1'b0, 1'b0);
        issue_ar(4'hD, 32'h1000_0008, 8'd0, 3'd3, 2'b01);
        collect_r(1, 1'b0);

        // Early wlast: SLVERR but both beats are still consumed
        wd[0] = 64'h1; wd[1] = 64'h2; ws[0] = 8'hFF; ws[1] = 8'hFF;
        write_burst(4'hE, 32'h1000_0300, 8'd1, 3'd3, 2'b01, 1'b1, 1'b0);

        // Same-cycle write and read of one word: read returns old data
        wd[0] = 64'hDEAD_BEEF_CAFE_F00D; ws[0] = 8'hFF;
        write_burst(4'h1, 32'h1000_0040, 8'd0, 3'd3, 2'b01, 1'b0, 1'b0);
        push_exp(4'h4, 32'h1000_0040, 8'd0, 3'd3, 2'b01);
        awid = 4'h2; awaddr = 32'h1000_0040; awlen = 0; awsize = 3; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'h4; araddr = 32'h1000_0040; arlen = 0; arsize = 3; arburst = 2'b01; arvalid = 1'b1;
        chk("conc_awready", awready, 1);
        chk("conc_arready", arready, 1);
        @(negedge aclk);
        awvalid = 1'b0; arvalid = 1'b0;
        wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'h0F; wlast = 1'b1; wvalid = 1'b1;
        chk("conc_wready", wready, 1);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
        model_write(8, 64'h0123_4567_89AB_CDEF, 8'h0F);
        wait_b(4'h2, 2'b00);
        collect_r(1, 1'b0);
        issue_ar(4'h5, 32'h1000_0040, 8'd0, 3'd3, 2'b01);
        collect_r(1, 1'b0);

        // Reset in the middle of a read burst
        for (int i = 0; i < 4; i++) begin wd[i] = 64'h7700 + 64'(i); ws[i] = 8'hFF; end
        write_burst(4'h3, 32'h1000_0200, 8'd3, 3'd3, 2'b01, 1'b0, 1'b0);
        issue_ar(4'h6, 32'h1000_0200, 8'd3, 3'd3, 2'b01);
        collect_r(1, 1'b0);
        #2 aresetn = 1'b0;
        #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rlast", rlast, 0);
        chk("midrst_arready", arready, 1);
        sb.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("postrst_arready", arready, 1);
        chk("postrst_awready", awready, 1);
        issue_ar(4'h7, 32'h1000_0200, 8'd0, 3'd3, 2'b01);
        collect_r(1, 1'b0);

        chk("sb_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 responder backing the 64-bit/4-bit-ID master port that the address-remapped memory path drives; terminates that port with an on-chip byte-enabled SRAM so the remapped window (0x1000_0000 region) is serviced without external DRAM. Read and write channels run independent state machines and may be active simultaneously. Used as the memory endpoint in FPGA bring-up and as a target in simulation.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 64, data width; fixed at 64 (8 byte lanes)
- ID_WIDTH, 4, AXI ID width
- MEM_WORDS, 4096, SRAM depth in 64-bit words (32 KiB), power of two
- BASE_NIBBLE, 4'h1, required value of addr[31:28]; otherwise DECERR
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- s_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos}  in  ID,ADDR,8,3,2,1,4,3,4  write address; lock/cache/prot/qos ignored
- s_axi_awvalid in 1 / s_axi_awready out 1  AW handshake
- s_axi_w{data,strb,last}  in  64,8,1  write data; s_axi_wvalid in 1 / s_axi_wready out 1
- s_axi_b{id,resp}  out  ID,2  write response; s_axi_bvalid out 1 / s_axi_bready in 1
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos}  in  as AW  read address; s_axi_arvalid in 1 / s_axi_arready out 1
- s_axi_r{data,id,resp,last}  out  64,ID,2,1  read data; s_axi_rvalid out 1 / s_axi_rready in 1

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. W_IDLE: awready=1; AW handshake latches id/addr/len/size/burst, clears beat count, error flag. W_DATA: wready=1; each W handshake writes wdata under wstrb at current word, advances address, increments count. Beat count authoritative: beat len+1 ends burst; wlast mismatch on any beat sets SLVERR. W_RESP: bvalid=1 until bready.
- Read FSM R_IDLE -> R_FETCH -> R_DATA -> R_IDLE. R_IDLE: arready=1; AR handshake latches fields. R_FETCH: issue SRAM read of first word. R_DATA: rvalid=1; on R handshake of non-last beat, next word read issued same cycle (back-to-back beats); rlast=1 on beat len+1; handshake of last beat -> R_IDLE.
- Address: word index = addr[log2(MEM_WORDS)+2:3]. FIXED: unchanged. INCR: +(1<<size). WRAP: wraps within (len+1)<<size aligned boundary. size>3 or burst=2'b11: whole burst SLVERR, INCR arithmetic, no writes.
- addr[31:28]!=BASE_NIBBLE: DECERR, writes suppressed, rdata=0. Error responses still consume/return all len+1 beats.
- Narrow transfers: full 64-bit word read; writes rely on wstrb.
- Same-cycle read and write to one word: read returns old data (read-first).
- rresp/bresp precedence: DECERR over SLVERR over OKAY.

## Timing
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=0, bid=rid=0, rdata=0. SRAM contents not cleared.
- AW accepted cycle t -> wready=1 at t+1; last W at t' -> bvalid at t'+1; awready at cycle after B handshake.
- AR accepted cycle t -> rvalid at t+2; then one beat per cycle while rready=1.
- rvalid/rdata/rlast/rid stable while rready=0; bvalid/bid/bresp stable while bready=0.
- Reset asserted mid-burst: both FSMs to IDLE immediately, valids drop, partial write remains in SRAM.

## Structure
- axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR/DECERR constants, next-address function (addr, size, len, burst).
- Sub-module sram_dp: one write port (8 byte enables), one synchronous read port with read enable, output held when not enabled, read-first collision.

## Test plan
- Single INCR write 0x1000_0008, wdata 0x1122334455667788, wstrb 0xFF, then read -> bresp=0, rdata matches, rlast=1, rvalid 2 cycles after AR.
- INCR len=7 write then read with rready toggling every other cycle -> 8 beats in order, rlast only on 8th, data held during stalls.
- WRAP len=3 size=3 at 0x1000_0018 -> beats hit 0x18,0x00,0x08,0x10.
- Write 0x2000_0000 len=1 -> bresp=2'b11 after 2 beats, SRAM unchanged; read same -> two beats rdata=0, rresp=2'b11.
- Concurrent INCR write and read to 0x1000_0040, wstrb 0x0F -> read sees old data; later read shows only low 4 bytes updated.
- aresetn low mid-read burst -> rvalid=0 same cycle, arready=1 after release, next read OKAY.
